// File: rtl/ov7670_captura_pixel_if.sv
// Bus between the OV7670 camera pins and the pixel capture stage.
// Camera side drives the sync/clock/data lines; the capture stage returns
// the assembled RGB565 pixel together with its coordinates.
interface ov7670_captura_pixel_if;
  logic        VSYNC;
  logic        HREF;
  logic        PCLK;
  logic [7:0]  D;
  logic [15:0] pixel;
  logic        pixel_valido;
  logic [9:0]  coluna;
  logic [8:0]  linha;

  modport master (
    output VSYNC, HREF, PCLK, D,
    input  pixel, pixel_valido, coluna, linha
  );

  modport slave (
    input  VSYNC, HREF, PCLK, D,
    output pixel, pixel_valido, coluna, linha
  );
endinterface

// File: rtl/ov7670_captura_pixel.sv
// OV7670 pixel capture: synchronises the camera bus into the system clock
// domain, pairs bytes into RGB565 pixels and captures one frame per arming.
module ov7670_captura_pixel #(
  parameter int LARGURA = 640,
  parameter int ALTURA  = 480,
  parameter int N_SYNC  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  habilita,
  ov7670_captura_pixel_if.slave cam,
  output logic                  fim_frame,
  output logic                  ocupado,
  output logic                  erro,
  output logic [3:0]            db_estado
);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    ESPERA  = 4'd1,
    CAPTURA = 4'd2,
    FIM     = 4'd3
  } estado_t;

  localparam logic [9:0] LARG = 10'(LARGURA);
  localparam logic [8:0] ALT  = 9'(ALTURA);

  estado_t estado, proximo;

  logic [N_SYNC-1:0] pclk_sh, vsync_sh, href_sh;
  logic [7:0]        d_sh [N_SYNC];
  logic              pclk_d, vsync_d, href_d;
  logic              pclk_s, vsync_s, href_s;
  logic [7:0]        d_s;
  logic              pclk_sub, vsync_fall, vsync_rise, href_fall;

  logic [9:0]        col;
  logic [8:0]        lin;
  logic              byte_sel;
  logic [7:0]        hi;

  assign pclk_s  = pclk_sh[N_SYNC-1];
  assign vsync_s = vsync_sh[N_SYNC-1];
  assign href_s  = href_sh[N_SYNC-1];
  assign d_s     = d_sh[N_SYNC-1];

  assign pclk_sub   = pclk_s & ~pclk_d;
  assign vsync_fall = ~vsync_s & vsync_d;
  assign vsync_rise = vsync_s & ~vsync_d;
  assign href_fall  = ~href_s & href_d;

  assign db_estado = estado;

  // Synchroniser chains; D travels through the same depth as PCLK so the
  // byte seen on a synced PCLK rising edge is the one sampled at the pin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pclk_sh  <= '0;
      vsync_sh <= '0;
      href_sh  <= '0;
      for (int i = 0; i < N_SYNC; i++) d_sh[i] <= '0;
      pclk_d   <= 1'b0;
      vsync_d  <= 1'b0;
      href_d   <= 1'b0;
    end else begin
      pclk_sh[0]  <= cam.PCLK;
      vsync_sh[0] <= cam.VSYNC;
      href_sh[0]  <= cam.HREF;
      d_sh[0]     <= cam.D;
      for (int i = 1; i < N_SYNC; i++) begin
        pclk_sh[i]  <= pclk_sh[i-1];
        vsync_sh[i] <= vsync_sh[i-1];
        href_sh[i]  <= href_sh[i-1];
        d_sh[i]     <= d_sh[i-1];
      end
      pclk_d  <= pclk_s;
      vsync_d <= vsync_s;
      href_d  <= href_s;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= proximo;
  end

  // Next state and status outputs; waiting for a VSYNC fall guarantees a
  // frame is never picked up half way through.
  always_comb begin
    proximo   = estado;
    ocupado   = 1'b0;
    fim_frame = 1'b0;
    case (estado)
      OCIOSO: if (habilita) proximo = ESPERA;
      ESPERA: begin
        ocupado = 1'b1;
        if (vsync_fall) proximo = CAPTURA;
      end
      CAPTURA: begin
        ocupado = 1'b1;
        if (vsync_rise) proximo = FIM;
      end
      FIM: begin
        fim_frame = 1'b1;
        proximo   = OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase
  end

  // Byte pairing, coordinate counters and the sticky error flag; pixels
  // outside the accepted window are dropped but flag an error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col              <= '0;
      lin              <= '0;
      byte_sel         <= 1'b0;
      hi               <= '0;
      erro             <= 1'b0;
      cam.pixel        <= '0;
      cam.coluna       <= '0;
      cam.linha        <= '0;
      cam.pixel_valido <= 1'b0;
    end else begin
      cam.pixel_valido <= 1'b0;
      if (estado == ESPERA) begin
        erro     <= 1'b0;
        col      <= '0;
        lin      <= '0;
        byte_sel <= 1'b0;
      end else if (estado == CAPTURA) begin
        if (pclk_sub && href_s) begin
          if (!byte_sel) begin
            hi       <= d_s;
            byte_sel <= 1'b1;
          end else begin
            byte_sel <= 1'b0;
            if (col < LARG && lin < ALT) begin
              cam.pixel        <= {hi, d_s};
              cam.coluna       <= col;
              cam.linha        <= lin;
              cam.pixel_valido <= 1'b1;
            end else begin
              erro <= 1'b1;
            end
            if (col < LARG) col <= col + 10'd1;
          end
        end else if (href_fall) begin
          if (byte_sel) erro <= 1'b1;
          if (col != 10'd0 && lin < ALT) lin <= lin + 9'd1;
          col      <= '0;
          byte_sel <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_captura_pixel.sv
// Testbench for ov7670_captura_pixel: drives camera frames and compares
// every pixel pulse against a frame-level reference model.
module tb_ov7670_captura_pixel;

  localparam int LARG = 4;
  localparam int ALT  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       habilita = 1'b0;
  logic       fim_frame, ocupado, erro;
  logic [3:0] db_estado;

  ov7670_captura_pixel_if cam ();

  ov7670_captura_pixel #(.LARGURA(LARG), .ALTURA(ALT), .N_SYNC(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .habilita (habilita),
    .cam      (cam),
    .fim_frame(fim_frame),
    .ocupado  (ocupado),
    .erro     (erro),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] px;
    int          col;
    int          lin;
  } exp_t;

  typedef struct {
    int nl;
    int nb;
    bit exp_erro;
    int exp_px;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;
  int   fims = 0;
  exp_t exp_q[$];
  exp_t e;
  int   fr_len[$];
  logic [7:0] fr_data[$];

  // Pixel monitor: every pulse must match the oldest expected pixel.
  always @(negedge clock) begin
    if (cam.pixel_valido) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pixel got px=%h col=%0d lin=%0d required no pulse",
                 cam.pixel, cam.coluna, cam.linha);
      end else begin
        e = exp_q.pop_front();
        if (cam.pixel !== e.px || int'(cam.coluna) != e.col || int'(cam.linha) != e.lin) begin
          failures++;
          $display("[TB] FAIL pixel got px=%h col=%0d lin=%0d required px=%h col=%0d lin=%0d",
                   cam.pixel, cam.coluna, cam.linha, e.px, e.col, e.lin);
        end
      end
    end
    if (fim_frame) fims++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    check_output(name,
                 {cam.pixel, cam.coluna, cam.linha, cam.pixel_valido, fim_frame, ocupado, erro, db_estado},
                 '0);
  endtask

  task automatic drive_byte(input logic [7:0] b);
    cam.D    = b;
    cam.PCLK = 1'b1;
    tick(2);
    cam.PCLK = 1'b0;
    tick(2);
  endtask

  // Build a frame: nb<0 picks a random byte count per line.
  task automatic build_frame(input int nl, input int nb, input bit f8first);
    int len;
    logic [7:0] v;
    fr_len.delete();
    fr_data.delete();
    for (int l = 0; l < nl; l++) begin
      len = (nb >= 0) ? nb : int'($urandom_range(0, 12));
      fr_len.push_back(len);
      for (int b = 0; b < len; b++) begin
        v = 8'($urandom);
        if (f8first && l == 0 && b == 0) v = 8'hF8;
        if (f8first && l == 0 && b == 1) v = 8'h00;
        fr_data.push_back(v);
      end
    end
  endtask

  // Reference model: pairs bytes per line; a line with any complete pixel
  // advances the row; anything past the window or an odd line is an error.
  task automatic model_frame(output bit err, output int npx);
    int idx = 0;
    int lin = 0;
    int pairs;
    exp_t x;
    err = 1'b0;
    npx = 0;
    for (int l = 0; l < fr_len.size(); l++) begin
      pairs = fr_len[l] / 2;
      if (fr_len[l] % 2 != 0) err = 1'b1;
      for (int c = 0; c < pairs; c++) begin
        if (c < LARG && lin < ALT) begin
          x.px  = {fr_data[idx + 2*c], fr_data[idx + 2*c + 1]};
          x.col = c;
          x.lin = lin;
          exp_q.push_back(x);
          npx++;
        end else begin
          err = 1'b1;
        end
      end
      if (pairs > 0 && lin < ALT) lin++;
      idx += fr_len[l];
    end
  endtask

  task automatic apply_stimulus();
    int idx = 0;
    cam.VSYNC = 1'b1;
    tick(6);
    cam.VSYNC = 1'b0;
    tick(4);
    for (int l = 0; l < fr_len.size(); l++) begin
      cam.HREF = 1'b1;
      tick(1);
      for (int b = 0; b < fr_len[l]; b++) begin
        drive_byte(fr_data[idx]);
        idx++;
      end
      cam.HREF = 1'b0;
      tick(4);
    end
    cam.VSYNC = 1'b1;
    tick(8);
  endtask

  task automatic run_frame(input int nl, input int nb, input bit f8first,
                           input bit expect_idle, output bit err, output int npx);
    int p0, f0;
    build_frame(nl, nb, f8first);
    model_frame(err, npx);
    p0 = pulses;
    f0 = fims;
    apply_stimulus();
    check_output("fim_frame_count", 32'(fims - f0), 32'd1);
    check_output("pixel_count", 32'(pulses - p0), 32'(npx));
    check_output("erro", {31'd0, erro}, {31'd0, err});
    check_output("pending_expected", 32'(exp_q.size()), 32'd0);
    if (expect_idle) check_output("idle_state", {ocupado, db_estado}, 5'd0);
  endtask

  vec_t vecs[6];
  bit   merr;
  int   mpx;
  int   p0, f0;

  initial begin
    vecs[0] = '{nl: 3, nb: 8,  exp_erro: 1'b0, exp_px: 12};
    vecs[1] = '{nl: 2, nb: 6,  exp_erro: 1'b0, exp_px: 6};
    vecs[2] = '{nl: 3, nb: 7,  exp_erro: 1'b1, exp_px: 9};
    vecs[3] = '{nl: 2, nb: 12, exp_erro: 1'b1, exp_px: 8};
    vecs[4] = '{nl: 4, nb: 8,  exp_erro: 1'b1, exp_px: 12};
    vecs[5] = '{nl: 1, nb: 2,  exp_erro: 1'b0, exp_px: 1};

    cam.VSYNC = 1'b1;
    cam.HREF  = 1'b0;
    cam.PCLK  = 1'b0;
    cam.D     = 8'h00;
    tick(3);
    check_all_zero("reset_state");
    reset = 1'b1;
    tick(4);
    check_output("idle_after_reset", {ocupado, db_estado}, 5'd0);

    // Table of frame shapes, each armed individually.
    for (int t = 0; t < 6; t++) begin
      habilita = 1'b1;
      tick(2);
      check_output("armed_state", {ocupado, db_estado}, {1'b1, 4'd1});
      habilita = 1'b0;
      run_frame(vecs[t].nl, vecs[t].nb, (t == 0), 1'b1, merr, mpx);
      check_output("table_erro", {31'd0, erro}, {31'd0, vecs[t].exp_erro});
      check_output("table_pixels", 32'(mpx), 32'(vecs[t].exp_px));
      if (t == 0) check_output("last_coord", {22'd0, cam.coluna, cam.linha}, {22'd0, 10'd3, 9'd2});
    end

    // Arming while a frame is already under way: that frame is skipped.
    cam.VSYNC = 1'b0;
    tick(6);
    p0 = pulses;
    f0 = fims;
    cam.HREF = 1'b1;
    tick(1);
    drive_byte(8'h12);
    drive_byte(8'h34);
    habilita = 1'b1;
    tick(2);
    habilita = 1'b0;
    check_output("mid_frame_arm_wait", {28'd0, db_estado}, 32'd1);
    drive_byte(8'h56);
    drive_byte(8'h78);
    cam.HREF = 1'b0;
    tick(4);
    cam.VSYNC = 1'b1;
    tick(8);
    check_output("skipped_frame_pixels", 32'(pulses - p0), 32'd0);
    check_output("skipped_frame_fim", 32'(fims - f0), 32'd0);
    check_output("still_waiting", {ocupado, db_estado}, {1'b1, 4'd1});
    run_frame(2, 8, 1'b0, 1'b1, merr, mpx);

    // Back-to-back frames with habilita held high.
    f0 = fims;
    habilita = 1'b1;
    tick(2);
    run_frame(3, 6, 1'b0, 1'b0, merr, mpx);
    habilita = 1'b0;
    run_frame(2, 4, 1'b0, 1'b1, merr, mpx);
    check_output("back_to_back_fims", 32'(fims - f0), 32'd2);

    // Randomised frame shapes.
    for (int r = 0; r < 8; r++) begin
      habilita = 1'b1;
      tick(2);
      habilita = 1'b0;
      run_frame(int'($urandom_range(1, 5)), -1, 1'b0, 1'b1, merr, mpx);
    end

    // Reset in the middle of a capture.
    habilita = 1'b1;
    tick(2);
    habilita = 1'b0;
    cam.VSYNC = 1'b1;
    tick(6);
    cam.VSYNC = 1'b0;
    tick(6);
    check_output("in_capture", {28'd0, db_estado}, 32'd2);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    tick(2);
    reset = 1'b1;
    p0 = pulses;
    f0 = fims;
    cam.HREF = 1'b1;
    tick(1);
    for (int b = 0; b < 4; b++) drive_byte(8'($urandom));
    cam.HREF = 1'b0;
    tick(4);
    cam.VSYNC = 1'b1;
    tick(8);
    check_output("post_reset_pixels", 32'(pulses - p0), 32'd0);
    check_output("post_reset_fim", 32'(fims - f0), 32'd0);
    check_output("post_reset_idle", {ocupado, erro, db_estado}, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
